// File: rtl/pwm_timer_mc_if.sv
// pwm_timer_mc_if: register-file config and status bundle for the
// multi-channel PWM timer.
interface pwm_timer_mc_if #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16,
    parameter int N_CH  = 4,
    parameter int DT_W  = 8
);
    logic                  en;
    logic [PSC_W-1:0]      psc;
    logic [1:0]            mode;
    logic [CNT_W-1:0]      arr;
    logic                  arpe;
    logic [N_CH*CNT_W-1:0] ccr;
    logic                  ccpe;
    logic [N_CH-1:0]       pol;
    logic [DT_W-1:0]       dtime;
    logic                  ug;
    logic [CNT_W-1:0]      cnt;
    logic                  dir;
    logic [N_CH-1:0]       out_p;
    logic [N_CH-1:0]       out_n;
    logic                  upd_irq;
    logic [N_CH-1:0]       cc_irq;

    modport master (
        output en, psc, mode, arr, arpe, ccr, ccpe, pol, dtime, ug,
        input  cnt, dir, out_p, out_n, upd_irq, cc_irq
    );

    modport slave (
        input  en, psc, mode, arr, arpe, ccr, ccpe, pol, dtime, ug,
        output cnt, dir, out_p, out_n, upd_irq, cc_irq
    );
endinterface

// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: prescaled up/down/centre counter with shadowed period and
// compare registers, driving complementary dead-time PWM pairs.
module pwm_timer_mc #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 16,
    parameter int N_CH  = 4,
    parameter int DT_W  = 8
) (
    input logic           clk,
    input logic           rst,
    pwm_timer_mc_if.slave bus
);
    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_CTR  = 2'b10;
    localparam logic [1:0] M_FRZ  = 2'b11;

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [PSC_W-1:0] P_ONE = PSC_W'(1);
    localparam logic [DT_W-1:0]  D_ONE = DT_W'(1);

    logic [PSC_W-1:0]             r_psc_cnt;
    logic [PSC_W-1:0]             r_psc_sh;
    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             r_arr_sh;
    logic                         r_dir;
    logic [N_CH*CNT_W-1:0]        r_ccr_sh;
    logic                         r_upd_irq;
    logic [N_CH-1:0]              r_cc_irq;
    logic [N_CH-1:0]              r_ref;
    logic [N_CH-1:0]              r_act_p;
    logic [N_CH-1:0]              r_act_n;
    logic [N_CH-1:0][DT_W-1:0]    r_dt;

    logic                         w_tick;
    logic                         w_uev;
    logic [CNT_W-1:0]             w_arr;
    logic [N_CH*CNT_W-1:0]        w_ccr;
    logic [CNT_W-1:0]             w_cnt_nx;
    logic                         w_dir_nx;
    logic [N_CH-1:0]              w_ref_nx;
    logic [N_CH-1:0]              w_cc_hit;

    // Unshadowed registers act on the live bus value straight away.
    assign w_tick = bus.en & (r_psc_cnt == r_psc_sh);
    assign w_arr  = bus.arpe ? r_arr_sh : bus.arr;
    assign w_ccr  = bus.ccpe ? r_ccr_sh : bus.ccr;

    always_comb begin
        w_cnt_nx = r_cnt;
        w_dir_nx = r_dir;
        w_uev    = 1'b0;
        if (bus.ug) begin
            w_uev = 1'b1;
            if (bus.mode == M_DOWN) begin
                w_cnt_nx = bus.arr;
                w_dir_nx = 1'b1;
            end else begin
                w_cnt_nx = '0;
                w_dir_nx = 1'b0;
            end
        end else if (w_tick) begin
            unique case (bus.mode)
                M_UP: begin
                    w_dir_nx = 1'b0;
                    if (r_cnt >= w_arr) begin
                        w_cnt_nx = '0;
                        w_uev    = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + C_ONE;
                    end
                end
                M_DOWN: begin
                    w_dir_nx = 1'b1;
                    if (r_cnt == '0) begin
                        w_cnt_nx = bus.arr;
                        w_uev    = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - C_ONE;
                    end
                end
                M_CTR: begin
                    if (w_arr == '0) begin
                        w_cnt_nx = '0;
                        w_dir_nx = 1'b0;
                        w_uev    = 1'b1;
                    end else if (!r_dir) begin
                        if (r_cnt >= w_arr) begin
                            w_cnt_nx = w_arr - C_ONE;
                            w_dir_nx = 1'b1;
                            w_uev    = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + C_ONE;
                        end
                    end else if (r_cnt == '0) begin
                        w_cnt_nx = C_ONE;
                        w_dir_nx = 1'b0;
                        w_uev    = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - C_ONE;
                    end
                end
                M_FRZ: begin
                    w_cnt_nx = r_cnt;
                end
            endcase
        end
    end

    always_comb begin
        w_ref_nx = '0;
        w_cc_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_ref_nx[i] = r_cnt < w_ccr[i*CNT_W +: CNT_W];
            w_cc_hit[i] = w_cnt_nx == w_ccr[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc_cnt <= '0;
            r_psc_sh  <= '0;
            r_cnt     <= '0;
            r_arr_sh  <= '0;
            r_dir     <= 1'b0;
            r_ccr_sh  <= '0;
            r_upd_irq <= 1'b0;
            r_cc_irq  <= '0;
        end else begin
            if (bus.ug || w_tick) begin
                r_psc_cnt <= '0;
            end else if (bus.en) begin
                r_psc_cnt <= r_psc_cnt + P_ONE;
            end
            if (w_uev) begin
                r_psc_sh <= bus.psc;
            end
            if (w_uev || !bus.arpe) begin
                r_arr_sh <= bus.arr;
            end
            if (w_uev || !bus.ccpe) begin
                r_ccr_sh <= bus.ccr;
            end
            r_cnt     <= w_cnt_nx;
            r_dir     <= w_dir_nx;
            r_upd_irq <= w_uev;
            r_cc_irq  <= (w_tick && !bus.ug && bus.mode != M_FRZ)
                       ? w_cc_hit : '0;
        end
    end

    // Dead time: both lines idle while the count runs; restart on any ref edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref   <= '0;
            r_act_p <= '0;
            r_act_n <= '0;
            r_dt    <= '0;
        end else begin
            r_ref <= w_ref_nx;
            for (int i = 0; i < N_CH; i++) begin
                if (w_ref_nx[i] != r_ref[i]) begin
                    if (bus.dtime == '0) begin
                        r_act_p[i] <= w_ref_nx[i];
                        r_act_n[i] <= ~w_ref_nx[i];
                        r_dt[i]    <= '0;
                    end else begin
                        r_act_p[i] <= 1'b0;
                        r_act_n[i] <= 1'b0;
                        r_dt[i]    <= bus.dtime;
                    end
                end else if (r_dt[i] > D_ONE) begin
                    r_dt[i] <= r_dt[i] - D_ONE;
                end else begin
                    r_dt[i]    <= '0;
                    r_act_p[i] <= r_ref[i];
                    r_act_n[i] <= ~r_ref[i];
                end
            end
        end
    end

    assign bus.cnt     = r_cnt;
    assign bus.dir     = r_dir;
    assign bus.upd_irq = r_upd_irq;
    assign bus.cc_irq  = r_cc_irq;
    assign bus.out_p   = bus.pol ^ r_act_p;
    assign bus.out_n   = bus.pol ^ r_act_n;
endmodule

// File: tb/tb_pwm_timer_mc.sv
// tb_pwm_timer_mc: directed vectors for counting modes, shadowing,
// dead time, polarity, software update and reset.
module tb_pwm_timer_mc;
    localparam int CNT_W = 16;
    localparam int PSC_W = 16;
    localparam int N_CH  = 4;
    localparam int DT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int e3c [11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    int e3d [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    int e3u [11] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    pwm_timer_mc_if #(
        .CNT_W(CNT_W), .PSC_W(PSC_W), .N_CH(N_CH), .DT_W(DT_W)
    ) bus ();

    pwm_timer_mc #(
        .CNT_W(CNT_W), .PSC_W(PSC_W), .N_CH(N_CH), .DT_W(DT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input int p, input int a,
                         input int c0, input int dt,
                         input logic ap, input logic cp);
        bus.mode  = m;
        bus.psc   = PSC_W'(p);
        bus.arr   = CNT_W'(a);
        bus.ccr   = '0;
        bus.ccr[CNT_W-1:0] = CNT_W'(c0);
        bus.dtime = DT_W'(dt);
        bus.arpe  = ap;
        bus.ccpe  = cp;
        bus.en    = 1'b1;
        bus.ug    = 1'b1;
        step();
        bus.ug    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.en = 1'b0; bus.psc = '0; bus.mode = 2'b00; bus.arr = '0;
        bus.arpe = 1'b1; bus.ccr = '0; bus.ccpe = 1'b1;
        bus.pol = 4'b1010; bus.dtime = '0; bus.ug = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst cnt", bus.cnt, 0);
        chk("rst dir", bus.dir, 0);
        chk("rst upd", bus.upd_irq, 0);
        chk("rst cc", bus.cc_irq, 0);
        chk("rst out_p", bus.out_p, 4'b1010);
        chk("rst out_n", bus.out_n, 4'b1010);
        step();
        chk("rst hold cnt", bus.cnt, 0);
        rst = 1'b0;
        bus.pol = '0;
        step();

        // up, psc=1, arr=9, ccr0=3
        start(2'b00, 1, 9, 3, 0, 1'b1, 1'b1);
        chk("t1 upd0", bus.upd_irq, 1);
        for (int i = 1; i <= 40; i++) begin
            step();
            chk($sformatf("t1 cnt%0d", i), bus.cnt, (i / 2) % 10);
            chk($sformatf("t1 upd%0d", i), bus.upd_irq, (i % 20) == 0);
            chk($sformatf("t1 p%0d", i), bus.out_p[0],
                (((i - 1) / 2) % 10) < 3);
            chk($sformatf("t1 n%0d", i), bus.out_n[0],
                (((i - 1) / 2) % 10) >= 3);
        end

        // down, arr=4
        start(2'b01, 0, 4, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk($sformatf("t2 cnt%0d", i), bus.cnt, 4 - (i % 5));
            chk($sformatf("t2 upd%0d", i), bus.upd_irq, (i % 5) == 0);
            chk($sformatf("t2 dir%0d", i), bus.dir, 1);
        end

        // centre, arr=3
        start(2'b10, 0, 3, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) step();
            chk($sformatf("t3 cnt%0d", i), bus.cnt, e3c[i]);
            chk($sformatf("t3 dir%0d", i), bus.dir, e3d[i]);
            chk($sformatf("t3 upd%0d", i), bus.upd_irq, e3u[i]);
        end

        // dead time 3, then pol0=1
        start(2'b00, 0, 9, 5, 3, 1'b1, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            bus.pol[0] = (i > 30);
            step();
            if (i >= 11) begin
                chk($sformatf("t4 p%0d", i), bus.out_p[0],
                    (i > 30) ^ ((i % 10) == 4 || (i % 10) == 5));
                chk($sformatf("t4 n%0d", i), bus.out_n[0],
                    (i > 30) ^ ((i % 10) == 9 || (i % 10) == 0));
                chk($sformatf("t4 ovl%0d", i),
                    (bus.out_p[0] ^ bus.pol[0]) & (bus.out_n[0] ^ bus.pol[0]), 0);
            end
        end
        bus.pol = '0;

        // arpe=1: period change waits for UEV
        start(2'b00, 0, 9, 3, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            if (i == 7) bus.arr = 16'd4;
            step();
            chk($sformatf("t5a cnt%0d", i), bus.cnt,
                (i <= 9) ? i : ((i == 15) ? 0 : i - 10));
            chk($sformatf("t5a upd%0d", i), bus.upd_irq, i == 10 || i == 15);
            if (i == 3 || i == 4)
                chk($sformatf("t5a cc%0d", i), bus.cc_irq[0], i == 3);
        end

        // arpe=0: lowered period takes effect on next tick
        start(2'b00, 0, 9, 3, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 7) bus.arr = 16'd4;
            step();
            chk($sformatf("t5b cnt%0d", i), bus.cnt,
                (i <= 6) ? i : i - 7);
            chk($sformatf("t5b upd%0d", i), bus.upd_irq, i == 7);
        end

        // ug at cnt=7, then en=0 hold, then async reset
        start(2'b00, 0, 9, 0, 0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) step();
        chk("t6 cnt7", bus.cnt, 7);
        bus.arr = 16'd5;
        bus.ug  = 1'b1;
        step();
        bus.ug  = 1'b0;
        chk("t6 ug cnt", bus.cnt, 0);
        chk("t6 ug upd", bus.upd_irq, 1);
        for (int i = 9; i <= 14; i++) begin
            step();
            chk($sformatf("t6 cnt%0d", i), bus.cnt, (i == 14) ? 0 : i - 8);
            chk($sformatf("t6 upd%0d", i), bus.upd_irq, i == 14);
        end
        for (int i = 15; i <= 19; i++) step();
        chk("t6 cnt19", bus.cnt, 5);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6 hold%0d", i), bus.cnt, 5);
        end
        bus.pol = 4'b0101;
        rst = 1'b1;
        #1;
        chk("t6 rst cnt", bus.cnt, 0);
        chk("t6 rst dir", bus.dir, 0);
        chk("t6 rst upd", bus.upd_irq, 0);
        chk("t6 rst out_p", bus.out_p, 4'b0101);
        chk("t6 rst out_n", bus.out_n, 4'b0101);
        step();
        chk("t6 rst2 cnt", bus.cnt, 0);
        chk("t6 rst2 upd", bus.upd_irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
